// File: rtl/zynq_axil_csr_bank_pkg.sv
// Shared AXI-Lite constants, FSM state types and the address-to-word
// index shift used by the GP0 CSR bank.
package zynq_axil_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    function automatic int axil_word_shift(input int dw);
        return (dw == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/zynq_axil_strb_merge.sv
// Byte-strobe merge: each byte lane takes the new data when its strobe
// bit is set, otherwise keeps the old data.
module zynq_axil_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_old,
    input  logic [DATA_WIDTH-1:0]   i_new,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    output logic [DATA_WIDTH-1:0]   o_data
);

    always_comb begin
        o_data = i_old;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (i_strb[b]) o_data[b*8 +: 8] = i_new[b*8 +: 8];
        end
    end

endmodule

// File: rtl/zynq_axil_csr_bank.sv
// AXI4-Lite CSR/status register bank terminating PS GP0 in the PL shell.
// Optional 64-bit timestamp counter: define ZYNQ_AXIL_CSR_TIMESTAMP_EN.
module zynq_axil_csr_bank
    import zynq_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_CSR    = 16,
    parameter int NUM_STATUS = 8,
    parameter logic [DATA_WIDTH-1:0] CSR_RESET_VAL = '0
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [ADDR_WIDTH-1:0]         s_axil_awaddr,
    input  logic [2:0]                    s_axil_awprot,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [DATA_WIDTH-1:0]         s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]         s_axil_araddr,
    input  logic [2:0]                    s_axil_arprot,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    output logic [DATA_WIDTH-1:0]         s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,
    output logic [NUM_CSR*DATA_WIDTH-1:0] csr_data_o,
    output logic [NUM_CSR-1:0]            csr_wr_v_o,
    input  logic [((NUM_STATUS > 0) ? NUM_STATUS : 1)*DATA_WIDTH-1:0] status_i
);

    localparam int SHIFT  = axil_word_shift(DATA_WIDTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    wr_state_e r_wstate, w_wstate_nxt;
    rd_state_e r_rstate, w_rstate_nxt;

    logic [DATA_WIDTH-1:0] r_csr [NUM_CSR];
    logic [DATA_WIDTH-1:0] w_merged [NUM_CSR];
    logic [NUM_CSR-1:0]    w_wr_hit;
    logic [NUM_CSR-1:0]    r_wr_v;

    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [1:0]            r_bresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_commit, w_ar_hs;
    logic                  w_awready, w_wready, w_arready;
    logic [ADDR_WIDTH-1:0] w_eff_awaddr, w_widx, w_ridx;
    logic [DATA_WIDTH-1:0] w_eff_wdata, w_rd_data;
    logic [STRB_W-1:0]     w_eff_wstrb;
    logic [1:0]            w_rd_resp;
    logic                  w_unused;

`ifdef ZYNQ_AXIL_CSR_TIMESTAMP_EN
    logic [63:0] r_ts;
    logic [31:0] r_ts_shadow;
`endif

    assign w_unused = ^{s_axil_awprot, s_axil_arprot, status_i};

    // A held beat wins over the bus; the bus side only matters while its
    // ready is high, which the FSM guarantees excludes the held case.
    assign w_eff_awaddr = (r_wstate == W_HAVE_AW) ? r_awaddr : s_axil_awaddr;
    assign w_eff_wdata  = (r_wstate == W_HAVE_W)  ? r_wdata  : s_axil_wdata;
    assign w_eff_wstrb  = (r_wstate == W_HAVE_W)  ? r_wstrb  : s_axil_wstrb;
    assign w_widx       = w_eff_awaddr >> SHIFT;
    assign w_ridx       = s_axil_araddr >> SHIFT;

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_commit     = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                w_wready  = 1'b1;
                if (s_axil_awvalid && s_axil_wvalid) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (s_axil_awvalid) begin
                    w_wstate_nxt = W_HAVE_AW;
                end else if (s_axil_wvalid) begin
                    w_wstate_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                w_wready = 1'b1;
                if (s_axil_wvalid) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_HAVE_W: begin
                w_awready = 1'b1;
                if (s_axil_awvalid) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil_bready) w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    for (genvar g = 0; g < NUM_CSR; g++) begin : g_csr
        zynq_axil_strb_merge #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_merge (
            .i_old (r_csr[g]),
            .i_new (w_eff_wdata),
            .i_strb(w_eff_wstrb),
            .o_data(w_merged[g])
        );
        assign w_wr_hit[g] = w_commit && (w_widx == ADDR_WIDTH'(g));
        assign csr_data_o[g*DATA_WIDTH +: DATA_WIDTH] = r_csr[g];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= AXI_OKAY;
            r_wr_v   <= '0;
            for (int i = 0; i < NUM_CSR; i++) r_csr[i] <= CSR_RESET_VAL;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wr_v   <= w_wr_hit;
            if (w_awready && s_axil_awvalid) r_awaddr <= s_axil_awaddr;
            if (w_wready && s_axil_wvalid) begin
                r_wdata <= s_axil_wdata;
                r_wstrb <= s_axil_wstrb;
            end
            if (w_commit) r_bresp <= (|w_wr_hit) ? AXI_OKAY : AXI_SLVERR;
            for (int i = 0; i < NUM_CSR; i++) begin
                if (w_wr_hit[i]) r_csr[i] <= w_merged[i];
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_ar_hs      = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (s_axil_arvalid) begin
                    w_ar_hs      = 1'b1;
                    w_rstate_nxt = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axil_rready) w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = AXI_SLVERR;
        for (int i = 0; i < NUM_CSR; i++) begin
            if (w_ridx == ADDR_WIDTH'(i)) begin
                w_rd_data = r_csr[i];
                w_rd_resp = AXI_OKAY;
            end
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (w_ridx == ADDR_WIDTH'(NUM_CSR + i)) begin
                w_rd_data = status_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_rd_resp = AXI_OKAY;
            end
        end
`ifdef ZYNQ_AXIL_CSR_TIMESTAMP_EN
        if (w_ridx == ADDR_WIDTH'(NUM_CSR + NUM_STATUS)) begin
            w_rd_data = r_ts[DATA_WIDTH-1:0];
            w_rd_resp = AXI_OKAY;
        end
        if (DATA_WIDTH == 32 &&
            w_ridx == ADDR_WIDTH'(NUM_CSR + NUM_STATUS + 1)) begin
            w_rd_data = DATA_WIDTH'(r_ts_shadow);
            w_rd_resp = AXI_OKAY;
        end
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= AXI_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

`ifdef ZYNQ_AXIL_CSR_TIMESTAMP_EN
    // Low-word read latches the upper half so a following high read is atomic.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ts        <= '0;
            r_ts_shadow <= '0;
        end else begin
            r_ts <= r_ts + 64'd1;
            if (w_ar_hs && DATA_WIDTH == 32 &&
                w_ridx == ADDR_WIDTH'(NUM_CSR + NUM_STATUS))
                r_ts_shadow <= r_ts[63:32];
        end
    end
`endif

    assign s_axil_awready = w_awready;
    assign s_axil_wready  = w_wready;
    assign s_axil_bvalid  = (r_wstate == W_RESP);
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = w_arready;
    assign s_axil_rvalid  = (r_rstate == R_RESP);
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign csr_wr_v_o     = r_wr_v;

endmodule

// File: tb/tb_zynq_axil_csr_bank.sv
// Randomized bench for zynq_axil_csr_bank against an array-based model
// of the register map (default build, 32-bit data).
module tb_zynq_axil_csr_bank;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NC = 16;
    localparam int NS = 8;
    localparam int CW = NC * DW;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [CW-1:0] csr_data;
    logic [NC-1:0] csr_wr_v;
    logic [NS*DW-1:0] status;

    logic [31:0] m_csr [NC];
    logic [31:0] m_st  [NS];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 aclk = ~aclk;

    always_comb begin
        status = '0;
        for (int i = 0; i < NS; i++) status[i*DW +: DW] = m_st[i];
    end

    zynq_axil_csr_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CSR(NC), .NUM_STATUS(NS)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .csr_data_o(csr_data), .csr_wr_v_o(csr_wr_v), .status_i(status)
    );

    task automatic check(input string tag, input logic [CW-1:0] got,
                         input logic [CW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [CW-1:0] model_flat();
        logic [CW-1:0] f;
        for (int i = 0; i < NC; i++) f[i*DW +: DW] = m_csr[i];
        return f;
    endfunction

    function automatic void model_read(input logic [AW-1:0] a,
                                       output logic [31:0] d,
                                       output logic [1:0] r);
        int idx = int'(a) / 4;
        d = 32'h0;
        r = 2'b10;
        if (idx < NC) begin
            d = m_csr[idx];
            r = 2'b00;
        end else if (idx < NC + NS) begin
            d = m_st[idx-NC];
            r = 2'b00;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_csr[i] = 32'h0;
    endtask

    // AW/W are presented after aw_d / w_d cycles respectively.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_d,
                             input int w_d, input int b_d);
        int idx = int'(a) / 4;
        bit aw_done = 0, w_done = 0, aw_acc, w_acc;
        logic [NC-1:0] pulse = '0;
        logic [1:0] exp_resp = 2'b10;
        for (int c = 0; c < 32 && !(aw_done && w_done); c++) begin
            if (c == aw_d) begin awaddr = a; awvalid = 1'b1; end
            if (c == w_d) begin wdata = d; wstrb = s; wvalid = 1'b1; end
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            @(negedge aclk);
            if (aw_acc) begin awvalid = 1'b0; aw_done = 1; end
            if (w_acc) begin wvalid = 1'b0; w_done = 1; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
        if (idx < NC) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_csr[idx][b*8 +: 8] = d[b*8 +: 8];
            pulse[idx] = 1'b1;
            exp_resp = 2'b00;
        end
        check("bvalid", CW'(bvalid), CW'(1));
        check("bresp", CW'(bresp), CW'(exp_resp));
        check("wr_pulse", CW'(csr_wr_v), CW'(pulse));
        check("csr_data", csr_data, model_flat());
        repeat (b_d) @(negedge aclk);
        check("bvalid_hold", CW'(bvalid), CW'(1));
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("bvalid_drop", CW'(bvalid), CW'(0));
        check("wr_pulse_drop", CW'(csr_wr_v), CW'(0));
        check("awready_back", CW'({awready, wready}), CW'(2'b11));
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int hold);
        logic [31:0] ed;
        logic [1:0]  er;
        bit ok = 0, acc;
        araddr  = a;
        arvalid = 1'b1;
        ed = 32'h0;
        er = 2'b00;
        for (int c = 0; c < 32 && !ok; c++) begin
            acc = arready;
            if (acc) model_read(a, ed, er);
            @(negedge aclk);
            ok = acc;
        end
        arvalid = 1'b0;
        if (!ok) check("ar_handshake_timeout", 0, 1);
        for (int i = 0; i < NS; i++) m_st[i] = $urandom;
        check("rvalid", CW'(rvalid), CW'(1));
        check("rdata", CW'(rdata), CW'(ed));
        check("rresp", CW'(rresp), CW'(er));
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            check("rdata_hold", CW'({rvalid, rdata}), CW'({1'b1, ed}));
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        check("rvalid_drop", CW'(rvalid), CW'(0));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r = $urandom_range(0, 9);
        int idx;
        if (r < 5)      idx = $urandom_range(0, NC - 1);
        else if (r < 7) idx = $urandom_range(NC, NC + NS - 1);
        else            idx = $urandom_range(NC + NS + 2, 255);
        return AW'(idx * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        areset = 1'b1;
        {awaddr, araddr, awprot, arprot} = '0;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        wdata = '0;
        wstrb = '0;
        model_reset();
        for (int i = 0; i < NS; i++) m_st[i] = $urandom;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        check("rst_ready", CW'({awready, wready, arready}), CW'(3'b111));
        check("rst_valid", CW'({bvalid, rvalid}), CW'(2'b00));
        check("rst_resp", CW'({bresp, rresp, rdata}), CW'(0));
        check("rst_csr", csr_data, CW'(0));
        check("rst_pulse", CW'(csr_wr_v), CW'(0));

        axi_write(10'h008, 32'hDEADBEEF, 4'hF, 0, 2, 0);
        check("tp_w2_a", CW'(csr_data[64 +: 32]), CW'(32'hDEADBEEF));
        axi_write(10'h008, 32'h11223344, 4'h5, 2, 0, 1);
        check("tp_w2_b", CW'(csr_data[64 +: 32]), CW'(32'hDE22BE44));

        m_st[0] = 32'hCAFE0001;
        axi_read(10'h040, 5);
        axi_write(10'h040, 32'h12345678, 4'hF, 0, 0, 0);
        axi_read(10'h3FC, 2);
        axi_read(10'h060, 0);
        axi_write(10'h060, 32'h1, 4'hF, 1, 0, 0);
        axi_write(10'h00C, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);

        // Write commit and read acceptance on the same edge to CSR 0.
        awaddr = 10'h000; wdata = 32'h1; wstrb = 4'hF;
        araddr = 10'h000;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_edge_rdata", CW'(rdata), CW'(32'h0));
        check("same_edge_bvalid", CW'({bvalid, rvalid}), CW'(2'b11));
        m_csr[0] = 32'h1;
        bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        bready = 1'b0; rready = 1'b0;
        axi_read(10'h000, 0);

        // Reset with an AW held and a read response pending.
        awaddr = 10'h010; awvalid = 1'b1;
        araddr = 10'h008; arvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; arvalid = 1'b0;
        check("pre_rst_rvalid", CW'(rvalid), CW'(1));
        areset = 1'b1;
        #1;
        check("mid_rst_valid", CW'({bvalid, rvalid}), CW'(2'b00));
        check("mid_rst_csr", csr_data, CW'(0));
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_ready", CW'({awready, wready, arready}), CW'(3'b111));
        check("post_rst_valid", CW'({bvalid, rvalid, csr_wr_v}), CW'(0));

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 0)
                axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 3));
            else
                axi_read(rand_addr(), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
